// File: rtl/led_show_scheduler_pkg.sv
// Shared types and the LED pattern ROM for the LED show scheduler.
package led_show_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int STEPS = 10;
  localparam int PAT_W = 8;

  localparam logic [PAT_W-1:0] PAT_BOUNCE [STEPS] =
    '{8'h00, 8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'h18, 8'h24, 8'h42, 8'h81};
  localparam logic [PAT_W-1:0] PAT_WALK [STEPS] =
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF, 8'h00};
  localparam logic [PAT_W-1:0] PAT_BLINK [STEPS] =
    '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
  localparam logic [PAT_W-1:0] PAT_FILL [STEPS] =
    '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h00};

  // Out-of-range steps read as dark rather than wrapping.
  function automatic logic [PAT_W-1:0] pat_lut(input logic [1:0] sel, input logic [3:0] step);
    logic [PAT_W-1:0] v;
    v = '0;
    if (step < 4'(STEPS)) begin
      case (sel)
        2'd0:    v = PAT_BOUNCE[step];
        2'd1:    v = PAT_WALK[step];
        2'd2:    v = PAT_BLINK[step];
        default: v = PAT_FILL[step];
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/led_show_scheduler_if.sv
// Requester/LED bundle between condition logic and the show scheduler.
interface led_show_scheduler_if
  import led_show_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] pat_sel;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [PAT_W-1:0]  led;

  modport master (output req, output pat_sel, input gnt, input done, input busy, input led);
  modport slave  (input req, input pat_sel, output gnt, output done, output busy, output led);

endinterface

// File: rtl/led_show_scheduler_tick.sv
// Pattern-step divider: tick pulses once every TICK_DIV cycles; clr restarts the period.
module led_tick_gen #(
  parameter int TICK_DIV = 3500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_show_scheduler.sv
// Arbitrates the LED bank among requesters and plays a 10-step pattern per grant.
// Round-robin by default; LED_SHOW_FIXED_PRIO_EN selects lowest-index-wins priority.
module led_show_scheduler
  import led_show_pkg::*;
#(
  parameter int TICK_DIV = 3500000,
  parameter int NREQ     = 4
) (
  input logic           clk,
  input logic           rst_n,
  led_show_scheduler_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IW-1:0] idx_t;

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [1:0]       sel_q, sel_d;
  idx_t             win_q, win_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [PAT_W-1:0] led_q, led_d;

  logic tick, clr;
  logic found;
  idx_t arb_idx, cand;
  logic [1:0] arb_sel;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

`ifdef LED_SHOW_FIXED_PRIO_EN
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = idx_t'(k);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        arb_idx = cand;
      end
    end
  end
`else
  idx_t rr_ptr_q, rr_ptr_d;

  // Search order starts at rr_ptr and wraps, so the last winner goes to the back.
  always_comb begin
    found   = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = idx_t'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found   = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && found) rr_ptr_d = idx_t'((int'(arb_idx) + 1) % NREQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign arb_sel = bus.pat_sel[{arb_idx, 1'b0} +: 2];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sel_d   = sel_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    led_d   = led_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d        = RUN;
          win_d          = arb_idx;
          sel_d          = arb_sel;
          step_d         = '0;
          gnt_d          = '0;
          gnt_d[arb_idx] = 1'b1;
          led_d          = pat_lut(arb_sel, 4'd0);
          clr            = 1'b1;
        end
      end
      RUN: begin
        // A dropped request aborts even on the final tick, so no done is issued.
        if (!bus.req[win_q]) begin
          state_d = GAP;
          gnt_d   = '0;
          led_d   = '0;
          clr     = 1'b1;
        end else if (tick) begin
          if (step_q == 4'(STEPS - 1)) begin
            state_d       = GAP;
            gnt_d         = '0;
            led_d         = '0;
            done_d[win_q] = 1'b1;
            clr           = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            led_d  = pat_lut(sel_q, step_q + 4'd1);
          end
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      sel_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.led  = led_q;

endmodule

// File: tb/tb_led_show_scheduler.sv
// Directed and random stimulus against a trace-expanding reference of the LED show scheduler.
module tb_led_show_scheduler;

  localparam int TD = 4;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  led_show_scheduler_if #(.NREQ(NR)) bus ();

  led_show_scheduler #(.TICK_DIV(TD), .NREQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [7:0] led;
    logic       run;
  } exp_t;

  logic [7:0] pat_tab [4][10] = '{
    '{8'h00, 8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'h18, 8'h24, 8'h42, 8'h81},
    '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF, 8'h00},
    '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00},
    '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F, 8'h00}
  };

  exp_t       expq[$];
  exp_t       cur;
  int         m_win;
  int         m_rr;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] glog[$];
  logic [3:0] prev_gnt;
  logic [3:0] order_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  bit         saw_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    logic [1:0] c;
    for (int k = 0; k < 4; k++) begin
`ifdef LED_SHOW_FIXED_PRIO_EN
      c = 2'(k);
`else
      c = 2'((m_rr + k) % 4);
`endif
      if (r[c]) return int'(c);
    end
    return 0;
  endfunction

  // A granted show expands to 40 step cycles, a done cycle and 3 more dark gap cycles.
  task automatic push_show(input int w, input logic [1:0] p);
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << w;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < TD; c++) begin
        e = '0; e.gnt = oh; e.busy = 1'b1; e.led = pat_tab[p][4'(s)]; e.run = 1'b1;
        expq.push_back(e);
      end
    end
    e = '0; e.done = oh; e.busy = 1'b1;
    expq.push_back(e);
    for (int c = 1; c < TD; c++) begin
      e = '0; e.busy = 1'b1;
      expq.push_back(e);
    end
    m_win = w;
    m_rr  = (w + 1) % 4;
  endtask

  task automatic model_advance();
    exp_t e;
    int   w;
    logic [3:0] r;
    r = bus.req;
    if (cur.run && !r[2'(m_win)]) begin
      expq.delete();
      for (int c = 0; c < TD; c++) begin
        e = '0; e.busy = 1'b1;
        expq.push_back(e);
      end
    end else if (!cur.busy && expq.size() == 0 && r != 4'b0) begin
      w = pick(r);
      push_show(w, 2'(bus.pat_sel >> (2 * w)));
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = '0;
    if (expq.size() > 0) e = expq.pop_front();
    cur = e;
    chk("gnt",  32'(bus.gnt),  32'(e.gnt));
    chk("done", 32'(bus.done), 32'(e.done));
    chk("busy", 32'(bus.busy), 32'(e.busy));
    chk("led",  32'(bus.led),  32'(e.led));
    if (bus.gnt != 4'b0 && prev_gnt == 4'b0) glog.push_back(bus.gnt);
    prev_gnt = bus.gnt;
    saw_done = (bus.done != 4'b0);
  endtask

  task automatic cycle();
    model_advance();
    @(negedge clk);
    pop_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt",  32'(bus.gnt),  32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_led",  32'(bus.led),  32'h0);
    expq.delete();
    cur      = '0;
    m_rr     = 0;
    prev_gnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_done();
    int n;
    n = 0;
    saw_done = 1'b0;
    while (!saw_done && n < 300) begin
      cycle();
      n++;
    end
    chk("done_timeout", 32'(saw_done), 32'h1);
  endtask

  task automatic run_until_grants(input int k);
    int n;
    n = 0;
    while (glog.size() < k && n < 300) begin
      cycle();
      n++;
    end
    chk("grant_timeout", 32'(glog.size()), 32'(k));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.pat_sel = '0;
    cur         = '0;
    m_rr        = 0;
    m_win       = 0;
    prev_gnt    = '0;
    @(negedge clk);
    @(negedge clk);
    chk("init_gnt",  32'(bus.gnt),  32'h0);
    chk("init_done", 32'(bus.done), 32'h0);
    chk("init_busy", 32'(bus.busy), 32'h0);
    chk("init_led",  32'(bus.led),  32'h0);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Single bounce show on requester 0.
    bus.req = 4'b0001; bus.pat_sel = 8'h00;
    run_until_done();
    bus.req = 4'b0000;
    repeat (6) cycle();
    chk("s1_idle_busy", 32'(bus.busy), 32'h0);

    // All requesting: round-robin order from index 0.
    do_reset();
    glog.delete();
    bus.req = 4'b1111; bus.pat_sel = 8'h55;
    repeat (5) run_until_done();
    bus.req = 4'b0000;
    chk("rr_count", 32'(glog.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(glog[i]), 32'(order_rr[i]));
    repeat (6) cycle();

    // Abort in step 3 of the fill pattern.
    do_reset();
    bus.req = 4'b0010; bus.pat_sel = 8'h0C;
    repeat (14) cycle();
    chk("abort_pre_led", 32'(bus.led), 32'(pat_tab[3][3]));
    bus.req = 4'b0000;
    cycle();
    chk("abort_gnt",  32'(bus.gnt),  32'h0);
    chk("abort_led",  32'(bus.led),  32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    repeat (6) cycle();
    chk("abort_idle", 32'(bus.busy), 32'h0);

    // Late request from index 0 waits for the running blink show and its gap.
    do_reset();
    glog.delete();
    bus.req = 4'b0100; bus.pat_sel = 8'h20;
    repeat (15) cycle();
    bus.req = 4'b0101;
    run_until_done();
    bus.req = 4'b0001;
    run_until_done();
    bus.req = 4'b0000;
    chk("late_count", 32'(glog.size()), 32'd2);
    chk("late_first", 32'(glog[0]), 32'h4);
    chk("late_second", 32'(glog[1]), 32'h1);
    repeat (6) cycle();

    // Reset during step 5 of the second show; held requests restart from index 0.
    do_reset();
    glog.delete();
    bus.req = 4'b0011; bus.pat_sel = 8'h00;
    run_until_grants(2);
    repeat (21) cycle();
    chk("mid_led_step5", 32'(bus.led), 32'(pat_tab[0][5]));
    do_reset();
    glog.delete();
    run_until_grants(1);
    chk("post_rst_gnt", 32'(glog[0]), 32'h1);
    run_until_done();
    bus.req = 4'b0000;
    repeat (6) cycle();

    // Random request toggling and pattern churn.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle();
      if ($urandom_range(0, 29) == 0) begin
        logic [1:0] b;
        b = 2'($urandom_range(0, 3));
        bus.req[b] = ~bus.req[b];
      end
      bus.pat_sel = 8'($urandom);
    end
    bus.req = 4'b0000;
    repeat (50) cycle();

`ifdef LED_SHOW_FIXED_PRIO_EN
    do_reset();
    glog.delete();
    bus.req = 4'b1001; bus.pat_sel = 8'h00;
    repeat (3) run_until_done();
    bus.req = 4'b0000;
    chk("fp_count", 32'(glog.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("fp_winner", 32'(glog[i]), 32'h1);
    repeat (6) cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
